fc_layer_sequencer: RTL and testbench

Controller that runs one fully-connected layer on the 6-input MAC array (`PE_FC_array`). For each output neuron it walks the input vector in 6-element tiles:
- fetches the weight tile and input tile from on-chip buffers;
- loads the weights with `write_kernel`;
- drives `inputs_mac`;
- waits out the array latency;
- accumulates `output_mac` into a 32-bit sum.

The finished neuron sum (optionally ReLU'd) is emitted on a valid/ready result port. It sits between the layer-level control FSM / SRAM buffers and the array.

---
 rtl/fc_layer_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Tile sequencer for one fully-connected layer on the 6-lane MAC array:
// fetch weight/input tiles, load kernel, feed, wait out latency, accumulate, emit.
module fc_layer_sequencer #(
  parameter int INPUTS_MAC = 6,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int PIPE_LAT   = 2,
  parameter int TILE_W     = 8,
  parameter int OUT_W      = 10,
  parameter int W_ADDR_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [TILE_W-1:0]            n_tiles,
  input  logic [OUT_W-1:0]             n_outputs,
  input  logic                         relu_en,
  output logic                         busy,
  output logic                         done,
  output logic                         w_rd_en,
  output logic [W_ADDR_W-1:0]          w_rd_addr,
  input  logic [INPUTS_MAC*DATA_W-1:0] w_rd_data,
  output logic                         x_rd_en,
  output logic [TILE_W-1:0]            x_rd_addr,
  input  logic [INPUTS_MAC*DATA_W-1:0] x_rd_data,
  output logic                         write_kernel,
  output logic [INPUTS_MAC*DATA_W-1:0] weights,
  output logic [INPUTS_MAC*DATA_W-1:0] inputs_mac,
  input  logic [ACC_W-1:0]             output_mac,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ACC_W-1:0]             res_data,
  output logic [OUT_W-1:0]             res_index
);

  localparam int BUS_W = INPUTS_MAC * DATA_W;
  localparam int CNT_W = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
  // Last WAIT count value; unreachable when PIPE_LAT == 1 since FEED skips WAIT.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PIPE_LAT - 2);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_CAPTURE = 4'd2;
  localparam logic [3:0] S_KERNEL  = 4'd3;
  localparam logic [3:0] S_FEED    = 4'd4;
  localparam logic [3:0] S_WAIT    = 4'd5;
  localparam logic [3:0] S_ACC     = 4'd6;
  localparam logic [3:0] S_EMIT    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]          state_q,     state_d;
  logic [TILE_W-1:0]   n_tiles_q,   n_tiles_d;
  logic [OUT_W-1:0]    n_outputs_q, n_outputs_d;
  logic                relu_q,      relu_d;
  logic [OUT_W-1:0]    j_q,         j_d;
  logic [TILE_W-1:0]   t_q,         t_d;
  logic [W_ADDR_W-1:0] w_addr_q,    w_addr_d;
  logic [ACC_W-1:0]    acc_q,       acc_d;
  logic [BUS_W-1:0]    w_hold_q,    w_hold_d;
  logic [BUS_W-1:0]    x_hold_q,    x_hold_d;
  logic [CNT_W-1:0]    wait_q,      wait_d;

  always_comb begin
    state_d     = state_q;
    n_tiles_d   = n_tiles_q;
    n_outputs_d = n_outputs_q;
    relu_d      = relu_q;
    j_d         = j_q;
    t_d         = t_q;
    w_addr_d    = w_addr_q;
    acc_d       = acc_q;
    w_hold_d    = w_hold_q;
    x_hold_d    = x_hold_q;
    wait_d      = wait_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((n_tiles != '0) && (n_outputs != '0)) begin
            n_tiles_d   = n_tiles;
            n_outputs_d = n_outputs;
            relu_d      = relu_en;
            j_d         = '0;
            t_d         = '0;
            w_addr_d    = '0;
            acc_d       = '0;
            state_d     = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        w_hold_d = w_rd_data;
        x_hold_d = x_rd_data;
        state_d  = S_KERNEL;
      end
      S_KERNEL:  state_d = S_FEED;
      S_FEED: begin
        wait_d  = '0;
        state_d = (PIPE_LAT == 1) ? S_ACC : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_ACC;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_ACC: begin
        acc_d = acc_q + output_mac;
        // Weight address is j*n_tiles + t, which advances by one per tile across neurons.
        w_addr_d = w_addr_q + W_ADDR_W'(1);
        if (t_q == n_tiles_q - TILE_W'(1)) begin
          t_d     = '0;
          state_d = S_EMIT;
        end else begin
          t_d     = t_q + TILE_W'(1);
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          acc_d = '0;
          if (j_q == n_outputs_q - OUT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            j_d     = j_q + OUT_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      n_tiles_q   <= '0;
      n_outputs_q <= '0;
      relu_q      <= 1'b0;
      j_q         <= '0;
      t_q         <= '0;
      w_addr_q    <= '0;
      acc_q       <= '0;
      w_hold_q    <= '0;
      x_hold_q    <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      n_tiles_q   <= n_tiles_d;
      n_outputs_q <= n_outputs_d;
      relu_q      <= relu_d;
      j_q         <= j_d;
      t_q         <= t_d;
      w_addr_q    <= w_addr_d;
      acc_q       <= acc_d;
      w_hold_q    <= w_hold_d;
      x_hold_q    <= x_hold_d;
      wait_q      <= wait_d;
    end
  end

  always_comb begin
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    done         = (state_q == S_DONE);
    w_rd_en      = (state_q == S_FETCH);
    x_rd_en      = (state_q == S_FETCH);
    w_rd_addr    = w_addr_q;
    x_rd_addr    = t_q;
    write_kernel = (state_q == S_KERNEL);
    weights      = w_hold_q;
    inputs_mac   = ((state_q == S_FEED) || (state_q == S_WAIT)) ? x_hold_q : '0;
    res_valid    = (state_q == S_EMIT);
    res_index    = (state_q == S_EMIT) ? j_q : '0;
    res_data     = '0;
    if (state_q == S_EMIT) begin
      res_data = (relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Randomized bench for fc_layer_sequencer with behavioural buffer/array models
// and a per-neuron dot-product reference.
module tb_fc_layer_sequencer;
  localparam int INPUTS_MAC = 6;
  localparam int DATA_W     = 8;
  localparam int ACC_W      = 32;
  localparam int PIPE_LAT   = 2;
  localparam int TILE_W     = 8;
  localparam int OUT_W      = 10;
  localparam int W_ADDR_W   = 16;
  localparam int BUS_W      = INPUTS_MAC * DATA_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [TILE_W-1:0]   n_tiles;
  logic [OUT_W-1:0]    n_outputs;
  logic                relu_en;
  logic                busy, done;
  logic                w_rd_en, x_rd_en;
  logic [W_ADDR_W-1:0] w_rd_addr;
  logic [TILE_W-1:0]   x_rd_addr;
  logic [BUS_W-1:0]    w_rd_data, x_rd_data;
  logic                write_kernel;
  logic [BUS_W-1:0]    weights, inputs_mac;
  logic [ACC_W-1:0]    output_mac;
  logic                res_valid, res_ready;
  logic [ACC_W-1:0]    res_data;
  logic [OUT_W-1:0]    res_index;

  always #5 clk = ~clk;

  fc_layer_sequencer #(
    .INPUTS_MAC(INPUTS_MAC), .DATA_W(DATA_W), .ACC_W(ACC_W), .PIPE_LAT(PIPE_LAT),
    .TILE_W(TILE_W), .OUT_W(OUT_W), .W_ADDR_W(W_ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_tiles(n_tiles), .n_outputs(n_outputs),
    .relu_en(relu_en), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .write_kernel(write_kernel), .weights(weights), .inputs_mac(inputs_mac),
    .output_mac(output_mac), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_index(res_index)
  );

  // Buffers and MAC array models
  logic [BUS_W-1:0] wmem [256];
  logic [BUS_W-1:0] xmem [256];
  logic [BUS_W-1:0] kern_q;
  logic [ACC_W-1:0] pipe_q [PIPE_LAT];

  function automatic logic [ACC_W-1:0] dot(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b);
    int s;
    s = 0;
    for (int k = 0; k < INPUTS_MAC; k++)
      s += int'($signed(a[k*DATA_W +: DATA_W])) * int'($signed(b[k*DATA_W +: DATA_W]));
    return ACC_W'(s);
  endfunction

  always @(posedge clk) begin
    if (write_kernel) kern_q <= weights;
    pipe_q[0] <= dot(kern_q, inputs_mac);
    for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    w_rd_data <= w_rd_en ? wmem[w_rd_addr[7:0]] : BUS_W'({$urandom, $urandom});
    x_rd_data <= x_rd_en ? xmem[x_rd_addr]      : BUS_W'({$urandom, $urandom});
  end
  assign output_mac = pipe_q[PIPE_LAT-1];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // fill: 0 random, 1 all 127, 2 weights -1 / inputs 127
  // rmode: 0 ready always, 1 random ready, 2 ready low for 5 EMIT cycles then high
  task automatic run_layer(input int n, input int m, input bit relu, input int fill,
                           input int rmode, input bit poke_start);
    logic [ACC_W-1:0] exp_q[$];
    int               idx_q[$];
    int               wa_q[$];
    int               xa_q[$];
    logic [ACC_W-1:0] snap_d;
    logic [OUT_W-1:0] snap_i;
    int cycles, stalls, kcount, got, hold_cnt, s;
    bit prev_stall, r;

    for (int a = 0; a < n*m; a++)
      wmem[a] = (fill == 0) ? BUS_W'({$urandom, $urandom}) :
                (fill == 1) ? {INPUTS_MAC{8'd127}} : {INPUTS_MAC{8'hFF}};
    for (int t = 0; t < n; t++)
      xmem[t] = (fill == 0) ? BUS_W'({$urandom, $urandom}) : {INPUTS_MAC{8'd127}};

    for (int j = 0; j < m; j++) begin
      s = 0;
      for (int t = 0; t < n; t++) begin
        for (int k = 0; k < INPUTS_MAC; k++) begin
          logic [BUS_W-1:0] wv, xv;
          wv = wmem[j*n+t];
          xv = xmem[t];
          s += int'($signed(wv[k*DATA_W +: DATA_W])) * int'($signed(xv[k*DATA_W +: DATA_W]));
        end
        wa_q.push_back(j*n + t);
        xa_q.push_back(t);
      end
      exp_q.push_back((relu && s < 0) ? 32'd0 : 32'(s));
      idx_q.push_back(j);
    end

    @(negedge clk);
    n_tiles = TILE_W'(n); n_outputs = OUT_W'(m); relu_en = relu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tiles = TILE_W'($urandom); n_outputs = OUT_W'($urandom); relu_en = 1'($urandom);
    chk("busy_rise", 64'(busy), 64'd1);

    cycles = 1; stalls = 0; kcount = 0; got = 0; hold_cnt = 0; prev_stall = 1'b0;
    snap_d = '0; snap_i = '0;
    while (!done && cycles < 4000) begin
      if (w_rd_en) begin
        if (wa_q.size() == 0) chk("extra_read", 64'd1, 64'd0);
        else begin
          chk("w_addr", 64'(w_rd_addr), 64'(wa_q.pop_front()));
          chk("x_addr", 64'(x_rd_addr), 64'(xa_q.pop_front()));
          chk("x_en", 64'(x_rd_en), 64'd1);
        end
      end
      if (write_kernel) kcount++;
      if (prev_stall) begin
        chk("stall_valid", 64'(res_valid), 64'd1);
        chk("stall_data", 64'(res_data), 64'(snap_d));
        chk("stall_index", 64'(res_index), 64'(snap_i));
      end
      if (res_valid) chk("read_in_emit", 64'(w_rd_en), 64'd0);

      case (rmode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          r = (hold_cnt >= 5);
          if (res_valid && hold_cnt < 5) hold_cnt++;
        end
      endcase
      res_ready = r;
      if (res_valid && r) begin
        if (exp_q.size() == 0) chk("extra_result", 64'd1, 64'd0);
        else begin
          chk("res_data", 64'(res_data), 64'(exp_q.pop_front()));
          chk("res_index", 64'(res_index), 64'(idx_q.pop_front()));
        end
        got++;
      end
      prev_stall = res_valid && !r;
      if (prev_stall) begin
        stalls++;
        snap_d = res_data;
        snap_i = res_index;
      end
      start = (poke_start && cycles == 6);
      if (start) begin
        n_tiles = 8'd1; n_outputs = 10'd1;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("result_count", 64'(got), 64'(m));
    chk("kernel_loads", 64'(kcount), 64'(n*m));
    chk("reads_left", 64'(wa_q.size()), 64'd0);
    chk("layer_cycles", 64'(cycles), 64'(m*(n*(PIPE_LAT+4)+1) + 1 + stalls));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("valid_after", 64'(res_valid), 64'd0);
  endtask

  task automatic zero_start(input int n, input int m);
    @(negedge clk);
    n_tiles = TILE_W'(n); n_outputs = OUT_W'(m); relu_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_rd", 64'({w_rd_en, x_rd_en, res_valid}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zero_quiet", 64'({res_valid, w_rd_en, x_rd_en, busy, done}), 64'd0);
    end
  endtask

  task automatic reset_mid_wait();
    int guard;
    for (int a = 0; a < 4; a++) wmem[a] = {INPUTS_MAC{8'd127}};
    for (int t = 0; t < 2; t++) xmem[t] = {INPUTS_MAC{8'd127}};
    res_ready = 1'b1;
    @(negedge clk);
    n_tiles = 8'd2; n_outputs = 10'd2; relu_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!res_valid && guard < 200) begin @(negedge clk); guard++; end
    while (inputs_mac == '0 && guard < 200) begin @(negedge clk); guard++; end
    chk("reach_feed_n1", 64'(guard < 200), 64'd1);
    @(negedge clk);
    chk("in_wait_n1", 64'(inputs_mac != '0), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_ctrl", 64'({busy, done, w_rd_en, x_rd_en, write_kernel, res_valid}), 64'd0);
    chk("rst_weights", 64'(weights), 64'd0);
    chk("rst_inputs", 64'(inputs_mac), 64'd0);
    chk("rst_result", 64'({res_data, res_index}), 64'd0);
    chk("rst_addr", 64'({w_rd_addr, x_rd_addr}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'({res_valid, busy, done, w_rd_en}), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; n_tiles = '0; n_outputs = '0; relu_en = 1'b0; res_ready = 1'b0;
    #1;
    chk("reset_ctrl", 64'({busy, done, w_rd_en, x_rd_en, write_kernel, res_valid}), 64'd0);
    chk("reset_buses", 64'(weights | inputs_mac), 64'd0);
    chk("reset_result", 64'({res_data, res_index}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_layer(1, 1, 1'b0, 1, 0, 1'b0);
    run_layer(2, 3, 1'b0, 1, 0, 1'b0);
    run_layer(1, 1, 1'b0, 2, 0, 1'b0);
    run_layer(1, 1, 1'b1, 2, 0, 1'b0);
    run_layer(2, 2, 1'b0, 0, 2, 1'b0);
    zero_start(0, 3);
    zero_start(4, 0);
    run_layer(3, 2, 1'b0, 0, 0, 1'b1);
    reset_mid_wait();
    run_layer(2, 2, 1'b0, 1, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_layer($urandom_range(1, 5), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
